// File: rtl/gpio_cmd_regfile.sv
// Processor GPIO command decoder: an edge-qualified strobe executes one command per rising edge of i_gpo[23].
// Drives datapath control bits, log-memory readout, BER counter snapshots and a sticky command-error flag.
module gpio_cmd_regfile #(
   parameter int NB_ADD_MEM = 15,
   parameter int N_BER_CH   = 2
) (
   input  logic                    clk,
   input  logic                    i_rst,
   input  logic [31:0]             i_gpo,
   input  logic [31:0]             i_data_log_from_mem,
   input  logic                    i_mem_full,
   input  logic [64*N_BER_CH-1:0]  i_ber_samp,
   input  logic [64*N_BER_CH-1:0]  i_ber_error,
   output logic [31:0]             o_gpi,
   output logic                    o_rst,
   output logic                    o_enbTx,
   output logic                    o_enbRx,
   output logic [1:0]              o_phase_sel,
   output logic                    o_run_log,
   output logic                    o_read_log,
   output logic [NB_ADD_MEM-1:0]   o_addr_log_to_mem,
   output logic                    o_cmd_err
);

   localparam logic [7:0] CMD_RESET     = 8'd0;
   localparam logic [7:0] CMD_EN_TX     = 8'd1;
   localparam logic [7:0] CMD_EN_RX     = 8'd2;
   localparam logic [7:0] CMD_PH_SEL    = 8'd3;
   localparam logic [7:0] CMD_RUN_MEM   = 8'd4;
   localparam logic [7:0] CMD_READ_MEM  = 8'd5;
   localparam logic [7:0] CMD_READ_NEXT = 8'd6;
   localparam logic [7:0] CMD_BER_SNAP  = 8'd7;
   localparam logic [7:0] CMD_BER_READ  = 8'd8;
   localparam logic [7:0] CMD_IS_FULL   = 8'd9;
   localparam logic [7:0] CMD_CLR_ERR   = 8'd10;

   logic                  r_prev_en;
   logic [31:0]           r_gpi;
   logic                  r_rst;
   logic                  r_enb_tx;
   logic                  r_enb_rx;
   logic [1:0]            r_phase_sel;
   logic                  r_run_log;
   logic                  r_read_log;
   logic [NB_ADD_MEM-1:0] r_addr;
   logic                  r_cmd_err;
   logic [63:0]           r_snap_samp;
   logic [63:0]           r_snap_err;

   logic [7:0]            w_cmd;
   logic [22:0]           w_data;
   logic [7:0]            w_ch;
   logic                  w_exec;
   logic                  w_ch_ok;
   logic                  w_err;
   logic [63:0]           w_sel_samp;
   logic [63:0]           w_sel_err;
   logic [31:0]           w_snap_word;
   logic                  w_unused;

   assign w_cmd    = i_gpo[31:24];
   assign w_data   = i_gpo[22:0];
   assign w_ch     = w_data[7:0];
   assign w_exec   = i_gpo[23] & ~r_prev_en;
   assign w_ch_ok  = int'(w_ch) < N_BER_CH;
   assign w_unused = ^w_data;

   always_comb begin
      w_sel_samp = '0;
      w_sel_err  = '0;
      for (int k = 0; k < N_BER_CH; k++) begin
         if (w_ch == 8'(k)) begin
            w_sel_samp = i_ber_samp[64*k +: 64];
            w_sel_err  = i_ber_error[64*k +: 64];
         end
      end
   end

   always_comb begin
      case (w_data[1:0])
         2'd0:    w_snap_word = r_snap_samp[31:0];
         2'd1:    w_snap_word = r_snap_samp[63:32];
         2'd2:    w_snap_word = r_snap_err[31:0];
         default: w_snap_word = r_snap_err[63:32];
      endcase
   end

   // Argument checks for commands that can be refused; codes above CLR_ERR are always illegal.
   always_comb begin
      w_err = 1'b0;
      case (w_cmd)
         CMD_READ_MEM:  w_err = ~i_mem_full;
         CMD_READ_NEXT: w_err = ~r_read_log;
         CMD_BER_SNAP:  w_err = ~w_ch_ok;
         default:       w_err = (w_cmd > CMD_CLR_ERR);
      endcase
   end

   always_ff @(posedge clk) begin
      if (i_rst) begin
         r_prev_en   <= 1'b1;
         r_gpi       <= '0;
         r_rst       <= 1'b0;
         r_enb_tx    <= 1'b0;
         r_enb_rx    <= 1'b0;
         r_phase_sel <= '0;
         r_run_log   <= 1'b0;
         r_read_log  <= 1'b0;
         r_addr      <= '0;
         r_cmd_err   <= 1'b0;
         r_snap_samp <= '0;
         r_snap_err  <= '0;
      end else begin
         r_prev_en <= i_gpo[23];
         if (r_run_log && i_mem_full)
            r_run_log <= 1'b0;
         if (w_exec && w_err) begin
            r_cmd_err <= 1'b1;
            r_gpi     <= {16'hDEAD, 8'h00, w_cmd};
         end else if (w_exec) begin
            case (w_cmd)
               CMD_RESET:     r_rst       <= w_data[0];
               CMD_EN_TX:     r_enb_tx    <= w_data[0];
               CMD_EN_RX:     r_enb_rx    <= w_data[0];
               CMD_PH_SEL:    r_phase_sel <= w_data[1:0];
               CMD_RUN_MEM: begin
                  r_run_log  <= 1'b1;
                  r_read_log <= 1'b0;
               end
               CMD_READ_MEM: begin
                  r_read_log <= 1'b1;
                  r_run_log  <= 1'b0;
                  r_addr     <= w_data[NB_ADD_MEM-1:0];
               end
               CMD_READ_NEXT: r_addr <= r_addr + 1'b1;
               CMD_BER_SNAP: begin
                  r_snap_samp <= w_sel_samp;
                  r_snap_err  <= w_sel_err;
               end
               CMD_BER_READ:  r_gpi <= w_snap_word;
               CMD_IS_FULL:   r_gpi <= {31'b0, i_mem_full};
               CMD_CLR_ERR: begin
                  r_cmd_err <= 1'b0;
                  r_gpi     <= '0;
               end
               default: ;
            endcase
         end else if (r_read_log) begin
            r_gpi <= i_data_log_from_mem;
         end
      end
   end

   assign o_gpi             = r_gpi;
   assign o_rst             = r_rst;
   assign o_enbTx           = r_enb_tx;
   assign o_enbRx           = r_enb_rx;
   assign o_phase_sel       = r_phase_sel;
   assign o_run_log         = r_run_log;
   assign o_read_log        = r_read_log;
   assign o_addr_log_to_mem = r_addr;
   assign o_cmd_err         = r_cmd_err;

endmodule

// File: tb/tb_gpio_cmd_regfile.sv
// Directed bench for gpio_cmd_regfile: expected values are queued as stimulus is driven and popped when outputs are sampled.
module tb_gpio_cmd_regfile;
   localparam int NB  = 15;
   localparam int NCH = 2;

   logic              clk = 1'b0;
   logic              i_rst;
   logic [31:0]       i_gpo;
   logic [31:0]       i_data_log_from_mem;
   logic              i_mem_full;
   logic [64*NCH-1:0] i_ber_samp;
   logic [64*NCH-1:0] i_ber_error;
   logic [31:0]       o_gpi;
   logic              o_rst;
   logic              o_enbTx;
   logic              o_enbRx;
   logic [1:0]        o_phase_sel;
   logic              o_run_log;
   logic              o_read_log;
   logic [NB-1:0]     o_addr_log_to_mem;
   logic              o_cmd_err;

   always #5 clk = ~clk;

   gpio_cmd_regfile #(.NB_ADD_MEM(NB), .N_BER_CH(NCH)) dut (
      .clk(clk), .i_rst(i_rst), .i_gpo(i_gpo),
      .i_data_log_from_mem(i_data_log_from_mem), .i_mem_full(i_mem_full),
      .i_ber_samp(i_ber_samp), .i_ber_error(i_ber_error),
      .o_gpi(o_gpi), .o_rst(o_rst), .o_enbTx(o_enbTx), .o_enbRx(o_enbRx),
      .o_phase_sel(o_phase_sel), .o_run_log(o_run_log), .o_read_log(o_read_log),
      .o_addr_log_to_mem(o_addr_log_to_mem), .o_cmd_err(o_cmd_err)
   );

   typedef struct {
      string       tag;
      logic [31:0] val;
   } exp_t;

   exp_t exp_q[$];
   int   n_assert = 0;
   int   n_fail   = 0;

   function automatic logic [31:0] mkst(input bit rst, input bit tx, input bit rx, input bit [1:0] ph,
                                        input bit run, input bit rd, input bit err);
      return {24'b0, rst, tx, rx, ph, run, rd, err};
   endfunction

   function automatic logic [31:0] st();
      return {24'b0, o_rst, o_enbTx, o_enbRx, o_phase_sel, o_run_log, o_read_log, o_cmd_err};
   endfunction

   task automatic expect_val(input string tag, input logic [31:0] v);
      exp_t e;
      e.tag = tag;
      e.val = v;
      exp_q.push_back(e);
   endtask

   task automatic check(input logic [31:0] obs);
      exp_t e;
      n_assert++;
      if (exp_q.size() == 0) begin
         n_fail++;
         $error("FAIL scoreboard_empty observed=%h expected=queued_entry", obs);
      end else begin
         e = exp_q.pop_front();
         assert (obs === e.val) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
         end
      end
   endtask

   // One low clock guarantees a fresh strobe edge, then one clock with the strobe high.
   task automatic send(input logic [7:0] c, input logic [22:0] d);
      i_gpo = {c, 1'b0, d};
      @(negedge clk);
      i_gpo[23] = 1'b1;
      @(negedge clk);
      i_gpo[23] = 1'b0;
   endtask

   localparam logic [31:0] S = 32'h0000_0000 | {24'b0, 1'b0, 1'b1, 1'b1, 2'd2, 1'b0, 1'b0, 1'b0};

   initial begin
      i_rst               = 1'b1;
      i_gpo               = {8'd1, 1'b1, 23'd1};
      i_data_log_from_mem = 32'h0;
      i_mem_full          = 1'b0;
      i_ber_samp          = '0;
      i_ber_error         = '0;
      repeat (3) @(negedge clk);
      expect_val("rst_gpi", 32'h0);            check(o_gpi);
      expect_val("rst_status", 32'h0);         check(st());
      expect_val("rst_addr", 32'h0);           check(32'(o_addr_log_to_mem));

      // Strobe held high through reset release must not execute.
      i_rst = 1'b0;
      repeat (3) @(negedge clk);
      expect_val("held_through_reset", mkst(0,0,0,0,0,0,0)); check(st());
      i_gpo[23] = 1'b0;
      @(negedge clk);
      i_gpo[23] = 1'b1;
      @(negedge clk);
      expect_val("en_tx_after_rearm", mkst(0,1,0,0,0,0,0)); check(st());

      // Strobe held 10 clocks with data changing mid-way executes only the first command.
      i_gpo[23] = 1'b0;
      @(negedge clk);
      i_gpo = {8'd1, 1'b1, 23'd0};
      @(negedge clk);
      expect_val("en_tx0_first", mkst(0,0,0,0,0,0,0)); check(st());
      i_gpo[22:0] = 23'd1;
      repeat (9) @(negedge clk);
      expect_val("held_strobe_once", mkst(0,0,0,0,0,0,0)); check(st());
      i_gpo[23] = 1'b0;

      send(8'd1, 23'd1);  expect_val("en_tx", mkst(0,1,0,0,0,0,0));   check(st());
      send(8'd3, 23'd2);  expect_val("ph_sel", mkst(0,1,0,2,0,0,0));  check(st());
      send(8'd2, 23'd1);  expect_val("en_rx", mkst(0,1,1,2,0,0,0));   check(st());
      send(8'd0, 23'd1);  expect_val("soft_rst_on", mkst(1,1,1,2,0,0,0)); check(st());
      send(8'd0, 23'd0);  expect_val("soft_rst_off", S);              check(st());

      // BER snapshot of channel 1, then live counters move.
      i_ber_samp  = {64'h0000_0001_8000_0000, 64'h0BAD_0BAD_0BAD_0BAD};
      i_ber_error = {64'h1234_5678_9ABC_DEF0, 64'hCAFE_CAFE_CAFE_CAFE};
      send(8'd7, 23'd1);
      i_ber_samp  = {64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0002_0000_0003};
      i_ber_error = {64'hEEEE_EEEE_EEEE_EEEE, 64'h0000_0004_0000_0005};
      send(8'd8, 23'd1);  expect_val("ber_samp_hi", 32'h0000_0001);  check(o_gpi);
      send(8'd8, 23'd0);  expect_val("ber_samp_lo", 32'h8000_0000);  check(o_gpi);
      send(8'd8, 23'd2);  expect_val("ber_err_lo", 32'h9ABC_DEF0);   check(o_gpi);
      send(8'd8, 23'd3);  expect_val("ber_err_hi", 32'h1234_5678);   check(o_gpi);

      send(8'd7, 23'd2);  expect_val("snap_bad_ch_gpi", 32'hDEAD_0007); check(o_gpi);
      expect_val("snap_bad_ch_err", S | 32'h1);                         check(st());
      send(8'd8, 23'd1);  expect_val("snap_unchanged", 32'h0000_0001);  check(o_gpi);
      send(8'd10, 23'd0); expect_val("clr_err_status", S);              check(st());
      expect_val("clr_err_gpi", 32'h0);                                 check(o_gpi);
      send(8'd200, 23'd0); expect_val("illegal_cmd", 32'hDEAD_00C8);   check(o_gpi);
      send(8'd10, 23'd0);
      send(8'd7, 23'd0);
      send(8'd8, 23'd1);  expect_val("ber_ch0_samp_hi", 32'h0000_0002); check(o_gpi);
      send(8'd8, 23'd3);  expect_val("ber_ch0_err_hi", 32'h0000_0004);  check(o_gpi);

      send(8'd9, 23'd0);  expect_val("is_full_0", 32'h0);               check(o_gpi);
      send(8'd5, 23'h7FFF); expect_val("read_mem_notfull_gpi", 32'hDEAD_0005); check(o_gpi);
      expect_val("read_mem_notfull_st", S | 32'h1);                     check(st());
      send(8'd10, 23'd0);
      send(8'd6, 23'd0);  expect_val("read_next_idle", 32'hDEAD_0006);  check(o_gpi);
      send(8'd10, 23'd0);

      // Log capture: auto-clear on mem_full, and RUN_MEM winning over the auto-clear.
      send(8'd4, 23'd0);  expect_val("run_mem", S | 32'h4);             check(st());
      i_mem_full = 1'b1;
      @(negedge clk);
      expect_val("run_autoclear", S);                                   check(st());
      i_mem_full = 1'b0;
      send(8'd4, 23'd0);
      i_gpo = {8'd4, 1'b0, 23'd0};
      @(negedge clk);
      i_gpo[23]  = 1'b1;
      i_mem_full = 1'b1;
      @(negedge clk);
      i_gpo[23]  = 1'b0;
      expect_val("run_override", S | 32'h4);                            check(st());
      @(negedge clk);
      expect_val("run_clear_after", S);                                 check(st());

      send(8'd9, 23'd0);  expect_val("is_full_1", 32'h1);               check(o_gpi);
      i_data_log_from_mem = 32'h1111_1111;
      send(8'd5, 23'h7FFF);
      expect_val("read_mem_st", S | 32'h2);                             check(st());
      expect_val("read_mem_addr", 32'h7FFF);                            check(32'(o_addr_log_to_mem));
      expect_val("read_mem_gpi_hold", 32'h1);                           check(o_gpi);
      i_data_log_from_mem = 32'hA5A5_0001;
      @(negedge clk);
      expect_val("stream_1", 32'hA5A5_0001);                            check(o_gpi);
      i_data_log_from_mem = 32'hA5A5_0002;
      @(negedge clk);
      expect_val("stream_2", 32'hA5A5_0002);                            check(o_gpi);

      // READ_NEXT held high: wraps once to 0, command clock beats streaming.
      i_gpo = {8'd6, 1'b0, 23'd0};
      i_data_log_from_mem = 32'hA5A5_0003;
      @(negedge clk);
      expect_val("stream_3", 32'hA5A5_0003);                            check(o_gpi);
      i_gpo[23] = 1'b1;
      i_data_log_from_mem = 32'hA5A5_0004;
      @(negedge clk);
      expect_val("read_next_priority", 32'hA5A5_0003);                  check(o_gpi);
      expect_val("read_next_wrap", 32'h0);                              check(32'(o_addr_log_to_mem));
      repeat (5) @(negedge clk);
      expect_val("read_next_once", 32'h0);                              check(32'(o_addr_log_to_mem));
      expect_val("stream_while_held", 32'hA5A5_0004);                   check(o_gpi);
      i_gpo[23] = 1'b0;
      @(negedge clk);

      // Reset in the same clock as a fresh strobe: reset wins.
      i_rst = 1'b1;
      i_gpo = {8'd1, 1'b1, 23'd1};
      @(negedge clk);
      expect_val("reset_abort_st", 32'h0);                              check(st());
      expect_val("reset_abort_gpi", 32'h0);                             check(o_gpi);
      expect_val("reset_abort_addr", 32'h0);                            check(32'(o_addr_log_to_mem));
      @(negedge clk);
      i_rst = 1'b0;
      repeat (2) @(negedge clk);
      expect_val("post_reset_no_exec", 32'h0);                          check(st());
      i_gpo[23] = 1'b0;
      send(8'd8, 23'd1);  expect_val("snap_cleared", 32'h0);            check(o_gpi);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end
endmodule

// File: doc/gpio_cmd_regfile.md
GPIO_CMD_REGFILE -- requirements
Module: gpio_cmd_regfile

Interface
REQ-001 SHALL have parameter NB_ADD_MEM, default 15, meaning log-memory address width.
REQ-002 SHALL have parameter N_BER_CH, default 2, range 1..256, meaning number of BER channels.
REQ-003 SHALL have port clk, input, 1 bit, meaning the single clock for the block.
REQ-004 SHALL have port i_rst, input, 1 bit, meaning reset: synchronous, active-high.
REQ-005 SHALL have port i_gpo, input, 32 bits, meaning processor word: [31:24] command, [23] enable strobe, [22:0] data.
REQ-006 SHALL have port i_data_log_from_mem, input, 32 bits, meaning log-memory read data.
REQ-007 SHALL have port i_mem_full, input, 1 bit, meaning log memory capture complete.
REQ-008 SHALL have ports i_ber_samp and i_ber_error, input, 64*N_BER_CH bits each, meaning per-channel sample and error counters; channel k occupies [64k+63:64k].
REQ-009 SHALL have port o_gpi, output, 32 bits, meaning readback word to the processor.
REQ-010 SHALL have port o_rst, output, 1 bit, meaning datapath soft reset.
REQ-011 SHALL have ports o_enbTx and o_enbRx, output, 1 bit each, meaning transmitter and receiver enables.
REQ-012 SHALL have port o_phase_sel, output, 2 bits, meaning receiver phase selection.
REQ-013 SHALL have ports o_run_log and o_read_log, output, 1 bit each, meaning log capture and log readout modes.
REQ-014 SHALL have port o_addr_log_to_mem, output, NB_ADD_MEM bits, meaning log read address.
REQ-015 SHALL have port o_cmd_err, output, 1 bit, meaning sticky error flag for an illegal command or argument.

Function
REQ-016 SHALL register i_gpo[23] as prev_enable; a command executes only on a clock where i_gpo[23]=1 and prev_enable=0; all effects appear one clock later.
REQ-017 SHALL decode the following commands (data = i_gpo[22:0]):
- 0 RESET: o_rst=data[0].
- 1 EN_TX: o_enbTx=data[0].
- 2 EN_RX: o_enbRx=data[0].
- 3 PH_SEL: o_phase_sel=data[1:0].
- 4 RUN_MEM: o_run_log=1, o_read_log=0.
- 5 READ_MEM: if i_mem_full=1, o_read_log=1, o_run_log=0, and o_addr_log_to_mem=data[NB_ADD_MEM-1:0]; otherwise error.
- 6 READ_NEXT: if o_read_log=1, o_addr_log_to_mem+1, wrapping from all-ones to 0; otherwise error.
- 7 BER_SNAP: if data[7:0] < N_BER_CH, latch both 64-bit counters of that channel into snapshot registers in the same clock; otherwise error and the snapshot is left unchanged.
- 8 BER_READ: o_gpi=snapshot word selected by data[1:0]: 0 samp[31:0], 1 samp[63:32], 2 err[31:0], 3 err[63:32].
- 9 IS_MEM_FULL: o_gpi={31'b0, i_mem_full}.
- 10 CLR_ERR: o_cmd_err=0, o_gpi=0.
- 11..255: error.
REQ-018 SHALL on error set o_cmd_err=1 and o_gpi={16'hDEAD, 8'h00, cmd}, leaving all other state unchanged.
REQ-019 SHALL, when o_read_log=1 and no command is executing, update o_gpi to i_data_log_from_mem every clock (1-cycle registered latency).
REQ-020 SHALL hold o_gpi when no command executes and o_read_log=0.
REQ-021 SHALL, when a command executes, have it take priority over the REQ-019 streaming update in that clock.
REQ-022 SHALL clear o_run_log to 0 one clock after i_mem_full is seen at 1 while o_run_log=1.
REQ-023 SHALL let a RUN_MEM command override the auto-clear of REQ-022 when both occur in the same clock.
REQ-024 SHALL ignore further commands while i_gpo[23] stays high; a new command requires i_gpo[23] to return to 0 for at least one clock.
REQ-025 SHALL keep snapshot values stable until the next valid BER_SNAP, independent of live counter changes.

Reset
REQ-026 SHALL, while i_rst=1, set to 0: o_gpi, o_rst, o_enbTx, o_enbRx, o_phase_sel, o_run_log, o_read_log, o_addr_log_to_mem, o_cmd_err, and the snapshots.
REQ-027 SHALL set prev_enable to 1 during reset, so an enable held high across reset does not execute a command.
REQ-028 SHALL abort an operation in progress on reset, with no command taking effect in any clock where i_rst=1.

Verification
REQ-029 SHALL cover: EN_TX data=1 strobe -> o_enbTx=1 one clock after the strobe; strobe held 10 clocks -> executes exactly once.
REQ-030 SHALL cover: N_BER_CH=2, ch1 samp=64'h0000_0001_8000_0000, BER_SNAP ch1, counter then changes, BER_READ word1 -> o_gpi=32'h0000_0001; word0 -> 32'h8000_0000.
REQ-031 SHALL cover: BER_SNAP ch=2 with N_BER_CH=2 -> o_cmd_err=1, o_gpi=32'hDEAD_0007, snapshot unchanged; CLR_ERR -> o_cmd_err=0.
REQ-032 SHALL cover: RUN_MEM, i_mem_full rises -> o_run_log=0; READ_MEM addr=all-ones -> o_read_log=1, o_gpi tracks memory data at 1-clock lag; READ_NEXT -> address 0.
REQ-033 SHALL cover: READ_MEM with i_mem_full=0 -> o_gpi=32'hDEAD_0005, o_read_log remains 0.
REQ-034 SHALL cover: i_gpo[23]=1 held through reset release -> no command executes; drop then raise -> executes.
